ifetch_unit: RTL and testbench

//   Instruction fetch stage directly downstream of the program counter.

---
 rtl/ifetch_unit.sv | 160 ++++++++++++++++
 tb/tb_ifetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage between the program counter and the decoder.
// Issues req/ack reads to instruction memory, holds the fetched word in the
// IR with a valid/ready handshake, and tells the PC when to advance.
// A one-entry skid buffer absorbs a word that arrives while the IR is full.
// Redirect flushes discard the IR, the skid word and any in-flight read.
module ifetch_unit #(
  parameter int unsigned AW      = 8,
  parameter int unsigned IW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic [IW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic          stop,
  output logic          fetch_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    LAUNCH = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] skid_data;
  logic [AW-1:0] skid_addr;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_nxt;
  logic          cnt_en;
  logic          slot_free;
  logic          advance;

  assign slot_free = ~ir_valid | ir_ready;
  assign cnt_en    = ((state == WAIT) || (state == DRAIN)) && !mem_ack;
  assign stop      = ~advance;

  // Commit strobe to the PC: one cycle per instruction entering the IR.
  always_comb begin
    advance = 1'b0;
    if (!rst && !flush) begin
      case (state)
        WAIT:    advance = mem_ack & slot_free;
        HOLD:    advance = ir_ready;
        default: advance = 1'b0;
      endcase
    end
  end

  // Timeout counter next value: cleared at launch, saturating on unacked cycles.
  always_comb begin
    tcnt_nxt = tcnt;
    if (state == LAUNCH) begin
      tcnt_nxt = '0;
    end else if (cnt_en && (tcnt != TMAX)) begin
      tcnt_nxt = tcnt + TW'(1);
    end
  end

  // Fetch FSM, IR/skid registers and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LAUNCH;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      ir        <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
      skid_data <= '0;
      skid_addr <= '0;
      tcnt      <= '0;
      fetch_err <= 1'b0;
    end else begin
      tcnt <= tcnt_nxt;
      if (cnt_en && (tcnt_nxt == TMAX)) begin
        fetch_err <= 1'b1;
      end

      // Default consume; a same-cycle commit below overrides it.
      if (ir_valid && ir_ready) begin
        ir_valid <= 1'b0;
      end

      if (flush) begin
        // Leaving HOLD discards the skid word; an outstanding read must still
        // be retired by its ack before a new request may launch.
        ir_valid <= 1'b0;
        case (state)
          WAIT, DRAIN: begin
            if (mem_ack) begin
              state   <= LAUNCH;
              mem_req <= 1'b0;
            end else begin
              state   <= DRAIN;
              mem_req <= 1'b1;
            end
          end
          default: begin
            state   <= LAUNCH;
            mem_req <= 1'b0;
          end
        endcase
      end else begin
        case (state)
          LAUNCH: begin
            mem_addr <= addr;
            mem_req  <= 1'b1;
            state    <= WAIT;
          end
          WAIT: begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              if (slot_free) begin
                ir       <= mem_rdata;
                ir_pc    <= mem_addr;
                ir_valid <= 1'b1;
                state    <= LAUNCH;
              end else begin
                skid_data <= mem_rdata;
                skid_addr <= mem_addr;
                state     <= HOLD;
              end
            end
          end
          HOLD: begin
            if (ir_ready) begin
              ir       <= skid_data;
              ir_pc    <= skid_addr;
              ir_valid <= 1'b1;
              state    <= LAUNCH;
            end
          end
          DRAIN: begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= LAUNCH;
            end
          end
          default: begin
            state   <= LAUNCH;
            mem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: per-cycle vector table for streaming,
// wait-state and skid behaviour, then hand sequences for flush, timeout
// and reset mid-fetch. The bench plays both the PC and instruction memory.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  addr;
  logic        flush;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        stop;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  ifetch_unit #(.AW(8), .IW(16), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .stop      (stop),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stop is checked before the edge with the row's inputs applied;
  // all other expectations are register values after that edge.
  typedef struct {
    logic        rst;
    logic [7:0]  addr;
    logic        flush;
    logic        ack;
    logic [15:0] rdata;
    logic        ready;
    logic        e_stop;
    logic        e_req;
    logic [7:0]  e_maddr;
    logic        e_valid;
    logic [7:0]  e_irpc;
    logic [15:0] e_ir;
    logic        e_err;
  } vec_t;

  vec_t tv[25];

  function automatic vec_t mk(
    input logic r, input logic [7:0] a, input logic f, input logic k,
    input logic [15:0] d, input logic rd,
    input logic es, input logic eq, input logic [7:0] ema, input logic ev,
    input logic [7:0] ep, input logic [15:0] ei, input logic ee);
    vec_t v;
    v.rst = r; v.addr = a; v.flush = f; v.ack = k; v.rdata = d; v.ready = rd;
    v.e_stop = es; v.e_req = eq; v.e_maddr = ema; v.e_valid = ev;
    v.e_irpc = ep; v.e_ir = ei; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] a, input logic f,
                       input logic k, input logic [15:0] d, input logic rd);
    rst = r; addr = a; flush = f; mem_ack = k; mem_rdata = d; ir_ready = rd;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; addr = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b1;

    //          rst addr  fl ack rdata     rdy  stop req maddr val irpc   ir        err
    tv[0]  = mk(1, 8'h00, 0, 0, 16'h0000, 1,   1,   0, 8'h00, 0, 8'h00, 16'h0000, 0);
    tv[1]  = mk(1, 8'h00, 0, 0, 16'h0000, 1,   1,   0, 8'h00, 0, 8'h00, 16'h0000, 0);
    tv[2]  = mk(0, 8'h00, 0, 0, 16'h0000, 1,   1,   1, 8'h00, 0, 8'h00, 16'h0000, 0);
    tv[3]  = mk(0, 8'h00, 0, 1, 16'hA000, 1,   0,   0, 8'h00, 1, 8'h00, 16'hA000, 0);
    tv[4]  = mk(0, 8'h01, 0, 0, 16'h0000, 1,   1,   1, 8'h01, 0, 8'h00, 16'hA000, 0);
    tv[5]  = mk(0, 8'h01, 0, 1, 16'hA001, 1,   0,   0, 8'h01, 1, 8'h01, 16'hA001, 0);
    tv[6]  = mk(0, 8'h02, 0, 0, 16'h0000, 1,   1,   1, 8'h02, 0, 8'h01, 16'hA001, 0);
    tv[7]  = mk(0, 8'h02, 0, 1, 16'hA002, 1,   0,   0, 8'h02, 1, 8'h02, 16'hA002, 0);
    tv[8]  = mk(0, 8'h03, 0, 0, 16'h0000, 1,   1,   1, 8'h03, 0, 8'h02, 16'hA002, 0);
    tv[9]  = mk(0, 8'h03, 0, 1, 16'hA003, 1,   0,   0, 8'h03, 1, 8'h03, 16'hA003, 0);
    // three wait states at 0x05
    tv[10] = mk(0, 8'h05, 0, 0, 16'h0000, 1,   1,   1, 8'h05, 0, 8'h03, 16'hA003, 0);
    tv[11] = mk(0, 8'h05, 0, 0, 16'h0000, 1,   1,   1, 8'h05, 0, 8'h03, 16'hA003, 0);
    tv[12] = mk(0, 8'h05, 0, 0, 16'h0000, 1,   1,   1, 8'h05, 0, 8'h03, 16'hA003, 0);
    tv[13] = mk(0, 8'h05, 0, 0, 16'h0000, 1,   1,   1, 8'h05, 0, 8'h03, 16'hA003, 0);
    tv[14] = mk(0, 8'h05, 0, 1, 16'hA005, 1,   0,   0, 8'h05, 1, 8'h05, 16'hA005, 0);
    // decoder stalls: second word goes to skid/HOLD
    tv[15] = mk(0, 8'h06, 0, 0, 16'h0000, 0,   1,   1, 8'h06, 1, 8'h05, 16'hA005, 0);
    tv[16] = mk(0, 8'h06, 0, 1, 16'hA006, 0,   1,   0, 8'h06, 1, 8'h05, 16'hA005, 0);
    tv[17] = mk(0, 8'h06, 0, 0, 16'h0000, 0,   1,   0, 8'h06, 1, 8'h05, 16'hA005, 0);
    tv[18] = mk(0, 8'h06, 0, 0, 16'h0000, 1,   0,   0, 8'h06, 1, 8'h06, 16'hA006, 0);
    tv[19] = mk(0, 8'h07, 0, 0, 16'h0000, 1,   1,   1, 8'h07, 0, 8'h06, 16'hA006, 0);
    tv[20] = mk(0, 8'h07, 0, 1, 16'hA007, 1,   0,   0, 8'h07, 1, 8'h07, 16'hA007, 0);
    // IR full but consumed in the ack cycle: direct load, no skid
    tv[21] = mk(0, 8'h08, 0, 0, 16'h0000, 0,   1,   1, 8'h08, 1, 8'h07, 16'hA007, 0);
    tv[22] = mk(0, 8'h08, 0, 1, 16'hA008, 1,   0,   0, 8'h08, 1, 8'h08, 16'hA008, 0);
    tv[23] = mk(0, 8'h09, 0, 0, 16'h0000, 1,   1,   1, 8'h09, 0, 8'h08, 16'hA008, 0);
    tv[24] = mk(0, 8'h09, 0, 1, 16'hA009, 1,   0,   0, 8'h09, 1, 8'h09, 16'hA009, 0);

    for (int i = 0; i < 25; i++) begin
      drive(tv[i].rst, tv[i].addr, tv[i].flush, tv[i].ack, tv[i].rdata, tv[i].ready);
      chk($sformatf("v%0d stop", i), 32'(stop), 32'(tv[i].e_stop));
      tick();
      chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(tv[i].e_req));
      chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(tv[i].e_maddr));
      chk($sformatf("v%0d ir_valid", i), 32'(ir_valid), 32'(tv[i].e_valid));
      chk($sformatf("v%0d ir_pc", i), 32'(ir_pc), 32'(tv[i].e_irpc));
      chk($sformatf("v%0d ir", i), 32'(ir), 32'(tv[i].e_ir));
      chk($sformatf("v%0d fetch_err", i), 32'(fetch_err), 32'(tv[i].e_err));
    end

    // Flush in WAIT without ack: DRAIN, acked data dropped, refetch at 0x40
    drive(0, 8'h10, 0, 0, 16'h0000, 0); chk("fl launch stop", 32'(stop), 32'd1); tick();
    chk("fl wait req", 32'(mem_req), 32'd1);
    chk("fl wait addr", 32'(mem_addr), 32'h10);
    chk("fl wait valid", 32'(ir_valid), 32'd1);
    drive(0, 8'h10, 1, 0, 16'h0000, 0); chk("fl flush stop", 32'(stop), 32'd1); tick();
    chk("fl drain req", 32'(mem_req), 32'd1);
    chk("fl drain addr", 32'(mem_addr), 32'h10);
    chk("fl drain valid", 32'(ir_valid), 32'd0);
    drive(0, 8'h40, 0, 1, 16'hBEEF, 1); chk("fl drain ack stop", 32'(stop), 32'd1); tick();
    chk("fl dropped req", 32'(mem_req), 32'd0);
    chk("fl dropped valid", 32'(ir_valid), 32'd0);
    chk("fl dropped ir", 32'(ir), 32'hA009);
    chk("fl dropped irpc", 32'(ir_pc), 32'h09);
    drive(0, 8'h40, 0, 0, 16'h0000, 1); tick();
    chk("fl redirect addr", 32'(mem_addr), 32'h40);
    chk("fl redirect req", 32'(mem_req), 32'd1);
    drive(0, 8'h40, 0, 1, 16'hA040, 1); chk("fl redirect stop", 32'(stop), 32'd0); tick();
    chk("fl redirect valid", 32'(ir_valid), 32'd1);
    chk("fl redirect irpc", 32'(ir_pc), 32'h40);
    chk("fl redirect ir", 32'(ir), 32'hA040);

    // Flush with a same-cycle ack: word dropped, straight to LAUNCH
    drive(0, 8'h41, 0, 0, 16'h0000, 0); tick();
    chk("fa wait valid", 32'(ir_valid), 32'd1);
    drive(0, 8'h41, 1, 1, 16'hDEAD, 0); chk("fa stop", 32'(stop), 32'd1); tick();
    chk("fa req", 32'(mem_req), 32'd0);
    chk("fa valid", 32'(ir_valid), 32'd0);
    chk("fa ir", 32'(ir), 32'hA040);

    // Timeout: 15 unacked cycles set the sticky error
    drive(0, 8'h50, 0, 0, 16'h0000, 1); tick();
    for (int i = 0; i < 14; i++) begin
      drive(0, 8'h50, 0, 0, 16'h0000, 1); tick();
    end
    chk("to err at 14", 32'(fetch_err), 32'd0);
    drive(0, 8'h50, 0, 0, 16'h0000, 1); tick();
    chk("to err at 15", 32'(fetch_err), 32'd1);
    chk("to req held", 32'(mem_req), 32'd1);
    for (int i = 0; i < 2; i++) begin
      drive(0, 8'h50, 0, 0, 16'h0000, 1); tick();
    end
    drive(0, 8'h50, 0, 1, 16'hA050, 1); chk("to late ack stop", 32'(stop), 32'd0); tick();
    chk("to late valid", 32'(ir_valid), 32'd1);
    chk("to late irpc", 32'(ir_pc), 32'h50);
    chk("to err sticky", 32'(fetch_err), 32'd1);
    drive(0, 8'h51, 0, 0, 16'h0000, 1); tick();
    chk("to err sticky2", 32'(fetch_err), 32'd1);
    chk("to next req", 32'(mem_req), 32'd1);

    // Reset mid-WAIT, then a stray ack during LAUNCH is ignored
    drive(1, 8'h51, 0, 0, 16'h0000, 1); chk("rs stop", 32'(stop), 32'd1); tick();
    chk("rs req", 32'(mem_req), 32'd0);
    chk("rs valid", 32'(ir_valid), 32'd0);
    chk("rs err", 32'(fetch_err), 32'd0);
    chk("rs maddr", 32'(mem_addr), 32'h00);
    chk("rs ir", 32'(ir), 32'h0000);
    drive(0, 8'h60, 0, 1, 16'hFFFF, 1); chk("rs stray stop", 32'(stop), 32'd1); tick();
    chk("rs stray req", 32'(mem_req), 32'd1);
    chk("rs stray maddr", 32'(mem_addr), 32'h60);
    chk("rs stray valid", 32'(ir_valid), 32'd0);
    chk("rs stray ir", 32'(ir), 32'h0000);
    drive(0, 8'h60, 0, 1, 16'hA060, 1); chk("rs fetch stop", 32'(stop), 32'd0); tick();
    chk("rs fetch valid", 32'(ir_valid), 32'd1);
    chk("rs fetch irpc", 32'(ir_pc), 32'h60);
    chk("rs fetch ir", 32'(ir), 32'hA060);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
